// File: rtl/mem_load_pkg.sv
// Shared types and helpers for the data-memory load engine.
package mem_load_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [TYPE_W-1:0] {
        LW  = 3'b000,
        LH  = 3'b001,
        LHU = 3'b010,
        LB  = 3'b011,
        LBU = 3'b100
    } load_type_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        ERR
    } state_e;

    // Unused encodings fold onto LW so downstream logic only sees legal types.
    function automatic load_type_e normalize_type(input logic [TYPE_W-1:0] raw);
        if (raw > TYPE_W'(3'b100)) begin
            return LW;
        end
        return load_type_e'(raw);
    endfunction

    function automatic logic is_misaligned(input load_type_e t, input logic [1:0] a);
        case (t)
            LH, LHU: return a[0];
            LB, LBU: return 1'b0;
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte/halfword/word lane selection with sign or zero extension.
module load_extract
    import mem_load_pkg::*;
(
    input  load_type_e        type_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
        case (type_i)
            LH:      ext_o = {{16{half_sel[15]}}, half_sel};
            LHU:     ext_o = {16'h0000, half_sel};
            LB:      ext_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     ext_o = {24'h000000, byte_sel};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Multicycle load engine: one word read per request, fixed memory latency,
// extended result registered into LoadData; misaligned requests are rejected.
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [TYPE_W-1:0] LoadType,
    input  logic [DATA_W-1:0] Addr,
    output logic              MemRead,
    output logic [DATA_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] LoadData,
    output logic              Done,
    output logic              Busy,
    output logic              AddrError
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    load_type_e         type_q, type_d;
    logic [DATA_W-1:0]  load_q, load_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_read_q, mem_read_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  ext_data;

    load_extract u_extract (
        .type_i    (type_q),
        .addr_lo_i (addr_q[1:0]),
        .data_i    (MemData),
        .ext_o     (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            type_q     <= LW;
            load_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            type_q     <= type_d;
            load_q     <= load_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_read_q <= mem_read_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        type_d  = type_q;
        load_d  = load_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    addr_d = Addr;
                    type_d = normalize_type(LoadType);
                    if (is_misaligned(normalize_type(LoadType), Addr[1:0])) begin
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = (MEM_LATENCY == 1) ? CAPT : WAIT;
            end
            WAIT: begin
                // Counter value 1 marks the cycle before data arrives.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPT: begin
                load_d  = ext_data;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they align with it.
        mem_read_d = (state_d == REQ);
        busy_d     = (state_d != IDLE);
    end

    assign MemRead   = mem_read_q;
    assign MemAddr   = {addr_q[DATA_W-1:2], 2'b00};
    assign LoadData  = load_q;
    assign Done      = done_q;
    assign Busy      = busy_q;
    assign AddrError = err_q;

endmodule
